reg_mem_bist: RTL and testbench



---
 rtl/reg_mem_bist_pkg.sv | 30 +++
 rtl/reg_mem_bist_if.sv | 28 ++
 rtl/reg_mem.sv | 23 ++
 rtl/reg_mem_bist.sv | 142 ++++++++++++++
 tb/tb_reg_mem_bist.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_mem_bist_pkg.sv
// Shared types and pattern helper for the reg_mem BIST initiator.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package reg_mem_bist_pkg;

    // Run phases of the self-test.
    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    // Working width of the pattern helper. Callers resize to their word width.
    // Only the low bits matter because the sum wraps modulo the word width.
    localparam int PAT_W = 32;

    // Expected word at an address: seed plus address, optionally inverted.
    function automatic logic [PAT_W-1:0] exp_pattern(
        input logic [PAT_W-1:0] seed,
        input logic [PAT_W-1:0] addr,
        input logic             inv
    );
        logic [PAT_W-1:0] sum;
        sum = seed + addr;
        return inv ? ~sum : sum;
    endfunction

endpackage

// File: rtl/reg_mem_bist_if.sv
// Memory-port bundle between the BIST initiator and reg_mem.
// Latency: read data returns one cycle after the address with wen low.
// Backpressure: none; the memory accepts one access per cycle.
interface reg_mem_bist_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5
);
    logic [ADDR_BITS-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic                  mem_wen;
    logic [DATA_WIDTH-1:0] mem_data_out;

    // Driving side (the BIST) owns address, write data and write enable.
    modport master (
        output mem_addr,
        output mem_data_in,
        output mem_wen,
        input  mem_data_out
    );

    // Memory side returns the read word.
    modport slave (
        input  mem_addr,
        input  mem_data_in,
        input  mem_wen,
        output mem_data_out
    );
endinterface

// File: rtl/reg_mem.sv
// Single-port register memory, write on rising edge, registered read.
// Latency: data_out valid one cycle after addr is presented.
// Backpressure: none; one access per cycle.
module reg_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5
) (
    input  logic                  clk,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wen,
    output logic [DATA_WIDTH-1:0] data_out
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

    // Write when enabled; always register the addressed word for readback.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[addr] <= data_in;
        end
        data_out <= mem[addr];
    end
endmodule

// File: rtl/reg_mem_bist.sv
// Write/read-back self-test of reg_mem with a seeded incrementing pattern.
// Latency: 2N+1 cycles from accepted start to done on a clean run (two passes
// with REG_MEM_BIST_INV_PASS_EN); start is ignored while busy, no backpressure.
module reg_mem_bist
    import reg_mem_bist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_BITS-1:0]  fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    reg_mem_bist_if.master        mem
);

    state_t                state;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [ADDR_BITS-1:0]  cmp_addr;   // address whose word arrives this cycle
    logic                  cmp_vld;    // a read word is due for comparison
    logic                  inv_cur;    // pattern polarity of the current pass
    logic [DATA_WIDTH-1:0] cmp_exp;
    logic [DATA_WIDTH-1:0] nxt_wr_dat;
    logic                  mismatch;

`ifdef REG_MEM_BIST_INV_PASS_EN
    logic                  inv_q;
    assign inv_cur = inv_q;
`else
    assign inv_cur = 1'b0;
`endif

    assign cmp_exp    = DATA_WIDTH'(exp_pattern(PAT_W'(seed_q), PAT_W'(cmp_addr), inv_cur));
    assign nxt_wr_dat = DATA_WIDTH'(exp_pattern(PAT_W'(seed_q),
                                                PAT_W'(mem.mem_addr) + PAT_W'(1), inv_cur));
    assign mismatch   = cmp_vld && (mem.mem_data_out != cmp_exp);

    // Run sequencer: drives the memory port, compares readback, reports result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail_addr       <= '0;
            fail_data       <= '0;
            mem.mem_addr    <= '0;
            mem.mem_data_in <= '0;
            mem.mem_wen     <= 1'b0;
            seed_q          <= '0;
            cmp_addr        <= '0;
            cmp_vld         <= 1'b0;
`ifdef REG_MEM_BIST_INV_PASS_EN
            inv_q           <= 1'b0;
`endif
        end else if ((state == READ || state == DRAIN) && mismatch) begin
            // First bad word ends the run; later addresses are not read.
            state        <= DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
            pass         <= 1'b0;
            fail_addr    <= cmp_addr;
            fail_data    <= mem.mem_data_out;
            mem.mem_addr <= '0;
            cmp_vld      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state           <= WRITE;
                        seed_q          <= seed;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        fail_addr       <= '0;
                        fail_data       <= '0;
                        mem.mem_wen     <= 1'b1;
                        mem.mem_addr    <= '0;
                        // exp(0) of the non-inverted pass is the seed itself.
                        mem.mem_data_in <= seed;
`ifdef REG_MEM_BIST_INV_PASS_EN
                        inv_q           <= 1'b0;
`endif
                    end
                end
                WRITE: begin
                    if (&mem.mem_addr) begin
                        state           <= READ;
                        mem.mem_wen     <= 1'b0;
                        mem.mem_addr    <= '0;
                        mem.mem_data_in <= '0;
                        cmp_vld         <= 1'b0;
                    end else begin
                        mem.mem_addr    <= mem.mem_addr + ADDR_BITS'(1);
                        mem.mem_data_in <= nxt_wr_dat;
                    end
                end
                READ: begin
                    // The address issued now is compared one cycle later.
                    cmp_vld  <= 1'b1;
                    cmp_addr <= mem.mem_addr;
                    if (&mem.mem_addr) begin
                        state        <= DRAIN;
                        mem.mem_addr <= '0;
                    end else begin
                        mem.mem_addr <= mem.mem_addr + ADDR_BITS'(1);
                    end
                end
                DRAIN: begin
                    cmp_vld <= 1'b0;
`ifdef REG_MEM_BIST_INV_PASS_EN
                    if (!inv_q) begin
                        // Clean first pass: rerun with the inverted pattern.
                        inv_q           <= 1'b1;
                        state           <= WRITE;
                        mem.mem_wen     <= 1'b1;
                        mem.mem_addr    <= '0;
                        mem.mem_data_in <= DATA_WIDTH'(exp_pattern(PAT_W'(seed_q), '0, 1'b1));
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end
`else
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_mem_bist.sv
`timescale 1ns/1ps
module tb_reg_mem_bist;
    localparam int DW       = 8;
    localparam int AB       = 5;
    localparam int N        = 32;
    localparam int PASS_LEN = 2 * N + 1;
`ifdef REG_MEM_BIST_INV_PASS_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] seed = '0;
    logic          busy, done, pass;
    logic [AB-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic          fault_en = 1'b0;
    logic [DW-1:0] mem_din;

    reg_mem_bist_if #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) mif ();

    reg_mem_bist #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .seed      (seed),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .mem       (mif)
    );

    // Stuck-at-0 on bit 3 of address 5 when fault_en is set.
    assign mem_din = mif.mem_data_in & ((fault_en && mif.mem_addr == 5'd5) ? 8'hF7 : 8'hFF);

    reg_mem #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) u_mem (
        .clk      (clk),
        .addr     (mif.mem_addr),
        .data_in  (mem_din),
        .wen      (mif.mem_wen),
        .data_out (mif.mem_data_out)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [7:0] m_seed;
    bit       m_fault;
    int       m_end;
    bit       m_failed;
    int       m_fa;
    bit [7:0] m_fd;

    function automatic bit [7:0] pat(input int a, input int p);
        bit [7:0] v;
        v = 8'(int'(m_seed) + a);
        return (p != 0) ? ~v : v;
    endfunction

    function automatic bit [7:0] stored(input int a, input int p);
        return pat(a, p) & ((m_fault && a == 5) ? 8'hF7 : 8'hFF);
    endfunction

    // Work out where the run ends and what failure, if any, it reports.
    task automatic model_run(input bit [7:0] s, input bit flt);
        m_seed   = s;
        m_fault  = flt;
        m_failed = 1'b0;
        m_fa     = 0;
        m_fd     = 8'h00;
        m_end    = NPASS * PASS_LEN;
        for (int p = 0; p < NPASS; p++) begin
            for (int a = 0; a < N; a++) begin
                if (!m_failed && stored(a, p) != pat(a, p)) begin
                    m_failed = 1'b1;
                    m_fa     = a;
                    m_fd     = stored(a, p);
                    m_end    = p * PASS_LEN + N + a + 2;
                end
            end
        end
    endtask

    int mdl_c  = 0;
    bit mdl_on = 1'b0;

    // Per-cycle comparison of every meaningful output against the model.
    always @(negedge clk) begin : cmp_blk
        int p;
        int r;
        if (mdl_on) begin
            if (mdl_c >= m_end) begin
                chk("m_busy_end", busy, 0);
                chk("m_done_end", done, 1);
                chk("m_pass_end", pass, !m_failed);
                chk("m_wen_end", mif.mem_wen, 0);
                chk("m_din_end", mif.mem_data_in, 0);
                if (m_failed) begin
                    chk("m_fail_addr", fail_addr, m_fa);
                    chk("m_fail_data", fail_data, m_fd);
                end
            end else begin
                p = mdl_c / PASS_LEN;
                r = mdl_c % PASS_LEN;
                chk("m_busy", busy, 1);
                chk("m_done", done, 0);
                if (r < N) begin
                    chk("m_wen_wr", mif.mem_wen, 1);
                    chk("m_addr_wr", mif.mem_addr, r);
                    chk("m_din_wr", mif.mem_data_in, pat(r, p));
                end else if (r < 2 * N) begin
                    chk("m_wen_rd", mif.mem_wen, 0);
                    chk("m_addr_rd", mif.mem_addr, r - N);
                    chk("m_din_rd", mif.mem_data_in, 0);
                end else begin
                    chk("m_wen_drain", mif.mem_wen, 0);
                    chk("m_din_drain", mif.mem_data_in, 0);
                end
            end
            mdl_c++;
        end
    end

    // ---------------- stimulus ----------------
    int       done_cyc;
    int       wr_cnt;
    logic [7:0] second_din;

    task automatic run_bist(input logic [7:0] s, input bit flt, input int dup_at, input int rst_at);
        fault_en = flt;
        model_run(s, flt);
        @(negedge clk);
        start = 1'b1;
        seed  = s;
        @(posedge clk);
        #1;
        start      = 1'b0;
        mdl_c      = 0;
        mdl_on     = 1'b1;
        done_cyc   = -1;
        wr_cnt     = 0;
        second_din = 8'h00;
        for (int c = 0; c <= m_end + 2; c++) begin
            @(negedge clk);
            if (done === 1'b1 && done_cyc < 0) done_cyc = c;
            if (mif.mem_wen === 1'b1) wr_cnt++;
            if (c == PASS_LEN) second_din = mif.mem_data_in;
            if (c == dup_at) begin
                start = 1'b1;
                seed  = 8'd99;
            end else begin
                start = 1'b0;
            end
            if (c == rst_at) begin
                rst_n = 1'b0;
                break;
            end
        end
        @(posedge clk);
        #1;
        mdl_on = 1'b0;
        start  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail_addr", fail_addr, 0);
        chk("rst_fail_data", fail_data, 0);
        chk("rst_mem_addr", mif.mem_addr, 0);
        chk("rst_mem_din", mif.mem_data_in, 0);
        chk("rst_mem_wen", mif.mem_wen, 0);
        rst_n = 1'b1;

        // Clean run, seed 10.
        run_bist(8'd10, 1'b0, -1, -1);
        chk("t1_done_cycle", done_cyc, NPASS * 65);
        chk("t1_write_count", wr_cnt, NPASS * 32);
        chk("t1_pass", pass, 1);
`ifdef REG_MEM_BIST_INV_PASS_EN
        chk("t1_inv_first_write", second_din, 8'hF5);
        chk("t1_mem0", u_mem.mem[0], 8'hF5);
        chk("t1_mem31", u_mem.mem[31], 8'hD6);
`else
        chk("t1_mem0", u_mem.mem[0], 8'h0A);
        chk("t1_mem31", u_mem.mem[31], 8'h29);
`endif

        // Stuck bit 3 at address 5.
        run_bist(8'd10, 1'b1, -1, -1);
        chk("t2_done_cycle", done_cyc, 39);
        chk("t2_pass", pass, 0);
        chk("t2_fail_addr", fail_addr, 5);
        chk("t2_fail_data", fail_data, 7);

        // Pattern wrap, seed F0.
        run_bist(8'hF0, 1'b0, -1, -1);
        chk("t3_pass", pass, 1);
`ifdef REG_MEM_BIST_INV_PASS_EN
        chk("t3_mem15", u_mem.mem[15], 8'h00);
        chk("t3_mem16", u_mem.mem[16], 8'hFF);
        chk("t3_mem31", u_mem.mem[31], 8'hF0);
`else
        chk("t3_mem15", u_mem.mem[15], 8'hFF);
        chk("t3_mem16", u_mem.mem[16], 8'h00);
        chk("t3_mem31", u_mem.mem[31], 8'h0F);
`endif

        // Reset during WRITE, then a clean run.
        run_bist(8'd10, 1'b0, -1, 10);
        @(negedge clk);
        chk("t4_wen", mif.mem_wen, 0);
        chk("t4_busy", busy, 0);
        chk("t4_done", done, 0);
        chk("t4_pass", pass, 0);
        rst_n = 1'b1;
        run_bist(8'd10, 1'b0, -1, -1);
        chk("t4_done_cycle", done_cyc, NPASS * 65);
        chk("t4_pass_after", pass, 1);

        // Second start while busy is ignored; seed 10 is still checked.
        run_bist(8'd10, 1'b0, 20, -1);
        chk("t5_done_cycle", done_cyc, NPASS * 65);
        chk("t5_pass", pass, 1);
        chk("t5_mem31", u_mem.mem[31], (NPASS == 2) ? 8'hD6 : 8'h29);

        // Restart straight from DONE with a new seed.
        run_bist(8'h55, 1'b0, -1, -1);
        chk("t6_done_cycle", done_cyc, NPASS * 65);
        chk("t6_pass", pass, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
